// File: rtl/zigbee_pkg.sv
// Shared types and constants for the ZigBee TX nibble path.
package zigbee_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } zbState_t;

    // Bits per 802.15.4 symbol (one nibble)
    localparam int ZB_SYM_BITS = 4;

    // Highest bit index within a symbol
    localparam logic [1:0] ZB_SEL_LAST = 2'(ZB_SYM_BITS - 1);

    // Default clock cycles per serialized bit
    localparam int ZB_TICK_DIV_DEFAULT = 4;

endpackage

// File: rtl/zigbee_tick_gen.sv
// Bit-period pacer: free-running modulo-TICK_DIV counter that only runs
// while 'run' is high. 'clear' restarts the period so a freshly loaded
// symbol always gets a full TICK_DIV cycles on its first bit.
module zigbee_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic inClock,
    input  logic inReset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Terminal count only counts as a tick while pacing is active
    assign tick = run && (cnt == CNT_LAST);

    // Counter: held at zero when idle or cleared, wraps after the last count
    always_ff @(posedge inClock) begin
        if (inReset || clear || !run) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/zigbee_nibble_serializer.sv
// Byte-to-symbol serializer feeding the 4:1 bit mux. Each accepted byte is
// emitted low nibble first, with outSel walking bit 0..3 once per bit-period.
// A new byte may be taken on the final tick of the high nibble so frames
// stream without an outValid gap.
module zigbee_nibble_serializer
    import zigbee_pkg::*;
#(
    parameter int TICK_DIV = ZB_TICK_DIV_DEFAULT
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic [7:0] inByte,
    input  logic       inLast,
    input  logic       inValid,
    output logic       outReady,
    output logic [3:0] outNibble,
    output logic [1:0] outSel,
    output logic       outValid,
    output logic       outSymStart,
    output logic       outFrameDone
);

    zbState_t   state, nextState;
    logic [7:0] byteReg, nextByte;
    logic       lastReg, nextLast;
    logic [3:0] nextNibble;
    logic [1:0] nextSel;
    logic       nextValid;
    logic       nextSymStart;
    logic       nextFrameDone;

    logic       tick;
    logic       load;
    logic       symEnd;
    logic       transfer;

    // Bit-period pacing; restarted on every byte load
    zigbee_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) uTickGen (
        .inClock (inClock),
        .inReset (inReset),
        .clear   (load),
        .run     (state != IDLE),
        .tick    (tick)
    );

    // Last bit-period of the current symbol is ending this cycle
    assign symEnd   = tick && (outSel == ZB_SEL_LAST);

    // Ready when idle, or exactly as the high nibble finishes
    assign outReady = !inReset &&
                      ((state == IDLE) || ((state == SHIFT_HI) && symEnd));

    assign transfer = inValid && outReady;

    // Next-state and next-output logic
    always_comb begin
        nextState     = state;
        nextByte      = byteReg;
        nextLast      = lastReg;
        nextNibble    = outNibble;
        nextSel       = outSel;
        nextValid     = outValid;
        nextSymStart  = 1'b0;
        nextFrameDone = 1'b0;
        load          = 1'b0;

        case (state)
            IDLE: begin
                if (transfer) begin
                    load         = 1'b1;
                    nextByte     = inByte;
                    nextLast     = inLast;
                    nextState    = SHIFT_LO;
                    nextNibble   = inByte[3:0];
                    nextSel      = 2'd0;
                    nextValid    = 1'b1;
                    nextSymStart = 1'b1;
                end
            end

            SHIFT_LO: begin
                if (symEnd) begin
                    nextState    = SHIFT_HI;
                    nextNibble   = byteReg[7:4];
                    nextSel      = 2'd0;
                    nextSymStart = 1'b1;
                end else if (tick) begin
                    nextSel = outSel + 2'd1;
                end
            end

            SHIFT_HI: begin
                if (symEnd) begin
                    // Frame end is reported even if the next frame starts now
                    nextFrameDone = lastReg;
                    if (transfer) begin
                        load         = 1'b1;
                        nextByte     = inByte;
                        nextLast     = inLast;
                        nextState    = SHIFT_LO;
                        nextNibble   = inByte[3:0];
                        nextSel      = 2'd0;
                        nextValid    = 1'b1;
                        nextSymStart = 1'b1;
                    end else begin
                        nextState  = IDLE;
                        nextNibble = 4'd0;
                        nextSel    = 2'd0;
                        nextValid  = 1'b0;
                    end
                end else if (tick) begin
                    nextSel = outSel + 2'd1;
                end
            end

            default: begin
                nextState  = IDLE;
                nextNibble = 4'd0;
                nextSel    = 2'd0;
                nextValid  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any byte in flight
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state        <= IDLE;
            byteReg      <= 8'd0;
            lastReg      <= 1'b0;
            outNibble    <= 4'd0;
            outSel       <= 2'd0;
            outValid     <= 1'b0;
            outSymStart  <= 1'b0;
            outFrameDone <= 1'b0;
        end else begin
            state        <= nextState;
            byteReg      <= nextByte;
            lastReg      <= nextLast;
            outNibble    <= nextNibble;
            outSel       <= nextSel;
            outValid     <= nextValid;
            outSymStart  <= nextSymStart;
            outFrameDone <= nextFrameDone;
        end
    end

endmodule

// File: tb/tb_zigbee_nibble_serializer.sv
// Directed bench for zigbee_nibble_serializer with TICK_DIV=4.
module tb_zigbee_nibble_serializer;

    logic       inClock = 1'b0;
    logic       inReset = 1'b1;
    logic [7:0] inByte  = 8'd0;
    logic       inLast  = 1'b0;
    logic       inValid = 1'b0;
    logic       outReady;
    logic [3:0] outNibble;
    logic [1:0] outSel;
    logic       outValid;
    logic       outSymStart;
    logic       outFrameDone;

    int checkCount = 0;
    int errorCount = 0;

    zigbee_nibble_serializer #(.TICK_DIV(4)) dut (
        .inClock      (inClock),
        .inReset      (inReset),
        .inByte       (inByte),
        .inLast       (inLast),
        .inValid      (inValid),
        .outReady     (outReady),
        .outNibble    (outNibble),
        .outSel       (outSel),
        .outValid     (outValid),
        .outSymStart  (outSymStart),
        .outFrameDone (outFrameDone)
    );

    always #5 inClock = ~inClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge inClock);
        #1;
    endtask

    // Offer a byte and wait (bounded) for it to be taken; returns in cycle 1
    task automatic accept(input logic [7:0] b, input logic last);
        int n = 0;
        inValid = 1'b1; inByte = b; inLast = last;
        @(negedge inClock);
        while (!outReady && n < 100) begin
            nextCycle();
            @(negedge inClock);
            n++;
        end
        check("acceptReady", outReady, 1);
        nextCycle();
        inValid = 1'b0; inByte = 8'd0; inLast = 1'b0;
    endtask

    // Check nCyc cycles of a byte whose emitted bit order is expBits[0..7].
    // Inputs are set to the follow-on offer for the whole window.
    task automatic serCheck(input logic [7:0] expBits, input int nCyc, input logic expFd1,
                            input logic nxtValid, input logic [7:0] nxtByte,
                            input logic nxtLast, input bit rndByte);
        logic [7:0] eb;
        eb = expBits;
        inValid = nxtValid; inByte = nxtByte; inLast = nxtLast;
        for (int k = 1; k <= nCyc; k++) begin
            if (rndByte) inByte = 8'($urandom);
            @(negedge inClock);
            check("valid",     outValid, 1);
            check("sel",       outSel, ((k - 1) / 4) % 4);
            check("nibble",    outNibble, (k <= 16) ? eb[3:0] : eb[7:4]);
            check("muxBit",    outNibble[outSel], eb[(k - 1) / 4]);
            check("symStart",  outSymStart, (k == 1 || k == 17));
            check("frameDone", outFrameDone, (k == 1) ? expFd1 : 1'b0);
            check("ready",     outReady, (k == 32));
            nextCycle();
        end
    endtask

    // Cycle after the final bit when no new byte followed
    task automatic endCheck(input logic expFd);
        @(negedge inClock);
        check("endValid",     outValid, 0);
        check("endNibble",    outNibble, 0);
        check("endSel",       outSel, 0);
        check("endFrameDone", outFrameDone, expFd);
        check("endReady",     outReady, 1);
        nextCycle();
    endtask

    initial begin
        int fdSeen;

        // 1: reset, then single 0xA5 with last
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge inClock);
            check("rstValid", outValid, 0);
            check("rstNibble", outNibble, 0);
            check("rstSel", outSel, 0);
            check("rstSym", outSymStart, 0);
            check("rstFd", outFrameDone, 0);
            check("rstReady", outReady, 0);
            nextCycle();
        end
        inReset = 1'b0;
        accept(8'hA5, 1'b1);
        serCheck(8'hA5, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        endCheck(1'b1);
        @(negedge inClock);
        check("fdOnePulse", outFrameDone, 0);
        check("idleValid", outValid, 0);
        nextCycle();

        // 2: back-to-back 0x3C then 0xF0, inValid held high
        accept(8'h3C, 1'b0);
        serCheck(8'h3C, 32, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
        inValid = 1'b0;
        serCheck(8'hF0, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        endCheck(1'b1);

        // 3: 10-cycle gap between bytes
        accept(8'h96, 1'b0);
        serCheck(8'h96, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge inClock);
            check("gapValid", outValid, 0);
            check("gapReady", outReady, 1);
            nextCycle();
        end
        accept(8'h69, 1'b1);
        serCheck(8'h69, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        endCheck(1'b1);

        // 4: reset at cycle 12 of 0x81
        accept(8'h81, 1'b1);
        serCheck(8'h81, 11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        inReset = 1'b1;
        @(negedge inClock);
        check("midRstReady", outReady, 0);
        nextCycle();
        inReset = 1'b0;
        @(negedge inClock);
        check("midRstValid", outValid, 0);
        check("midRstNibble", outNibble, 0);
        check("midRstSel", outSel, 0);
        check("midRstSym", outSymStart, 0);
        fdSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge inClock);
            if (outFrameDone) fdSeen++;
            nextCycle();
        end
        check("noFdAfterRst", fdSeen, 0);
        accept(8'h55, 1'b0);
        serCheck(8'h55, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        endCheck(1'b0);

        // 5: transfer offered during reset is dropped
        inReset = 1'b1; inValid = 1'b1; inByte = 8'hC3; inLast = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge inClock);
            check("rstOfferReady", outReady, 0);
            nextCycle();
        end
        inReset = 1'b0; inValid = 1'b0; inByte = 8'h00; inLast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge inClock);
            check("rstOfferValid", outValid, 0);
            check("rstOfferSym", outSymStart, 0);
            nextCycle();
        end

        // 6: inByte churns during serialization of 0x0F
        accept(8'h0F, 1'b1);
        serCheck(8'h0F, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        inByte = 8'h00;
        endCheck(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
